// File: rtl/reg_file_pkg.sv
// Shared constants for reg_file: reset values, register indices, and the strobe decode type.
package reg_file_pkg;

  localparam logic [7:0] REG2_RST = 8'h81;
  localparam logic [7:0] REG3_RST = 8'h20;

  localparam int unsigned REG_OP_A = 0;
  localparam int unsigned REG_OP_B = 1;
  localparam int unsigned REG_CFG0 = 2;
  localparam int unsigned REG_CFG1 = 3;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_BOTH  = 2'b11
  } op_e;

endpackage

// File: rtl/reg_file.sv
// Single-port register file: shared address, registered read, taps of regs 0-3.
// Optional macro REG_FILE_RW_BYPASS_EN: write-through read when wrEn and rdEn are both high.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int dataWidth = 8,
  parameter int depth     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [dataWidth-1:0]       wrData,
  input  logic [$clog2(depth)-1:0]   addr,
  input  logic                       wrEn,
  input  logic                       rdEn,
  output logic [dataWidth-1:0]       rdData,
  output logic                       rdData_valid,
  output logic [dataWidth-1:0]       reg_0,
  output logic [dataWidth-1:0]       reg_1,
  output logic [dataWidth-1:0]       reg_2,
  output logic [dataWidth-1:0]       reg_3
);

  localparam int AW = $clog2(depth);

  logic [dataWidth-1:0] mem [depth];
  logic                 in_range;
  op_e                  op;

  // Only non-power-of-two depths can address past the end of storage.
  generate
    if (depth == (1 << AW)) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_partial
      assign in_range = (32'(addr) < 32'(depth));
    end
  endgenerate

  assign op = op_e'({rdEn, wrEn});

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
      mem[REG_CFG0] <= dataWidth'(REG2_RST);
      mem[REG_CFG1] <= dataWidth'(REG3_RST);
      rdData        <= '0;
      rdData_valid  <= 1'b0;
    end else begin
      rdData_valid <= 1'b0;
      case (op)
        OP_WRITE: begin
          if (in_range) mem[addr] <= wrData;
        end
        OP_READ: begin
          rdData       <= in_range ? mem[addr] : '0;
          rdData_valid <= 1'b1;
        end
        OP_BOTH: begin
          if (in_range) mem[addr] <= wrData;
`ifdef REG_FILE_RW_BYPASS_EN
          rdData       <= wrData;
          rdData_valid <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign reg_0 = mem[REG_OP_A];
  assign reg_1 = mem[REG_OP_B];
  assign reg_2 = mem[REG_CFG0];
  assign reg_3 = mem[REG_CFG1];

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file at default parameters.
module tb_reg_file;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wrData;
  logic [3:0] addr;
  logic       wrEn;
  logic       rdEn;
  logic [7:0] rdData;
  logic       rdData_valid;
  logic [7:0] reg_0, reg_1, reg_2, reg_3;

  int errors = 0;
  int checks = 0;

  reg_file #(.dataWidth(8), .depth(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .wrData       (wrData),
    .addr         (addr),
    .wrEn         (wrEn),
    .rdEn         (rdEn),
    .rdData       (rdData),
    .rdData_valid (rdData_valid),
    .reg_0        (reg_0),
    .reg_1        (reg_1),
    .reg_2        (reg_2),
    .reg_3        (reg_3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply strobes, let one rising edge sample them, then settle 1 time unit.
  task automatic step(input logic r, input logic we, input logic re,
                      input logic [3:0] a, input logic [7:0] d);
    rst = r; wrEn = we; rdEn = re; addr = a; wrData = d;
    @(posedge clk);
    #1;
    rst = 1'b0; wrEn = 1'b0; rdEn = 1'b0;
  endtask

  logic [7:0] exp_rst [16];

  initial begin
    rst = 1'b0; wrEn = 1'b0; rdEn = 1'b0; addr = '0; wrData = '0;
    @(negedge clk);

    // Reset with both strobes active: strobes discarded.
    step(1'b1, 1'b1, 1'b1, 4'd0, 8'hA5);
    check("rst_reg0",  reg_0, 8'h00);
    check("rst_reg1",  reg_1, 8'h00);
    check("rst_reg2",  reg_2, 8'h81);
    check("rst_reg3",  reg_3, 8'h20);
    check("rst_rd",    rdData, 8'h00);
    check("rst_valid", rdData_valid, 1'b0);

    // Back-to-back reads of the whole file.
    for (int i = 0; i < 16; i++) exp_rst[i] = 8'h00;
    exp_rst[2] = 8'h81;
    exp_rst[3] = 8'h20;
    for (int i = 0; i < 16; i++) begin
      rst = 1'b0; wrEn = 1'b0; rdEn = 1'b1; addr = 4'(i);
      @(posedge clk);
      #1;
      check($sformatf("rd_rst_%0d", i), rdData, exp_rst[i]);
      check($sformatf("rd_rst_valid_%0d", i), rdData_valid, 1'b1);
    end
    rdEn = 1'b0;

    // Write then read.
    step(1'b0, 1'b1, 1'b0, 4'd5, 8'h10);
    check("wr5_valid", rdData_valid, 1'b0);
    check("wr5_rd_hold", rdData, 8'h00);
    step(1'b0, 1'b0, 1'b1, 4'd5, 8'h00);
    check("rd5", rdData, 8'h10);
    check("rd5_valid", rdData_valid, 1'b1);
    step(1'b0, 1'b1, 1'b0, 4'd3, 8'h15);
    check("wr3_tap", reg_3, 8'h15);
    check("wr3_rd_hold", rdData, 8'h10);
    step(1'b0, 1'b0, 1'b1, 4'd3, 8'h00);
    check("rd3", rdData, 8'h15);

    // Both strobes at addr 5.
    step(1'b0, 1'b1, 1'b1, 4'd5, 8'h3C);
`ifdef REG_FILE_RW_BYPASS_EN
    check("both_rd", rdData, 8'h3C);
    check("both_valid", rdData_valid, 1'b1);
`else
    check("both_rd", rdData, 8'h15);
    check("both_valid", rdData_valid, 1'b0);
`endif
    step(1'b0, 1'b0, 1'b1, 4'd5, 8'h00);
    check("both_wr_done", rdData, 8'h3C);

    // Idle after read, then overwrite the last-read address.
    step(1'b0, 1'b0, 1'b0, 4'd5, 8'h00);
    check("idle_valid", rdData_valid, 1'b0);
    check("idle_rd_hold", rdData, 8'h3C);
    step(1'b0, 1'b1, 1'b0, 4'd5, 8'h77);
    check("ovr_rd_hold", rdData, 8'h3C);
    check("ovr_valid", rdData_valid, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd5, 8'h00);
    check("ovr_rd", rdData, 8'h77);

    // Taps 0-2 and an upper register.
    step(1'b0, 1'b1, 1'b0, 4'd0, 8'hC3);
    step(1'b0, 1'b1, 1'b0, 4'd1, 8'h5A);
    step(1'b0, 1'b1, 1'b0, 4'd2, 8'hE7);
    step(1'b0, 1'b1, 1'b0, 4'd15, 8'hFE);
    check("tap0", reg_0, 8'hC3);
    check("tap1", reg_1, 8'h5A);
    check("tap2", reg_2, 8'hE7);
    check("tap3_kept", reg_3, 8'h15);
    step(1'b0, 1'b0, 1'b1, 4'd15, 8'h00);
    check("rd15", rdData, 8'hFE);
    step(1'b0, 1'b0, 1'b1, 4'd4, 8'h00);
    check("rd4", rdData, 8'h00);

    // Reset mid-operation with a write to addr 0.
    step(1'b1, 1'b1, 1'b0, 4'd0, 8'hA5);
    check("mrst_reg0", reg_0, 8'h00);
    check("mrst_reg2", reg_2, 8'h81);
    check("mrst_reg3", reg_3, 8'h20);
    check("mrst_rd", rdData, 8'h00);
    check("mrst_valid", rdData_valid, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd5, 8'h00);
    check("mrst_rd5", rdData, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
